// File: rtl/p18_lives_keeper.sv
// Lives bookkeeping and game-flow FSM for the breakout core: tracks remaining
// lives, serve/play/respawn/game-over phases and the frame-timed holds between them.
module p18_lives_keeper #(
  parameter logic [1:0] START_LIVES     = 2'd3,
  parameter logic [5:0] RESPAWN_FRAMES  = 6'd60,
  parameter logic [7:0] GAMEOVER_FRAMES = 8'd180
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       frame_start,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  input  logic       btn_start,
  output logic [1:0] lives,
  output logic       show_lives,
  output logic       ball_hold,
  output logic       playing,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ATTRACT,
    SERVE,
    PLAY,
    RESPAWN,
    GAME_OVER
  } state_t;

  state_t     state;
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_dec;
  logic       btn_meta;
  logic       btn_sync;
  logic       btn_prev;
  logic       start_edge;

  // NOTE: the synchronizer resets to 1 so a button already held while reset
  // is released looks like a steady high level, not a fresh press.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
      btn_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value
      // of its predecessor, forming a true shift chain.
      btn_meta <= btn_start;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign start_edge    = btn_sync & ~btn_prev;
  assign frame_cnt_dec = frame_cnt - 8'd1;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= ATTRACT;
      lives      <= 2'd0;
      show_lives <= 1'b1;
      ball_hold  <= 1'b1;
      playing    <= 1'b0;
      game_over  <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      case (state)
        ATTRACT: begin
          if (start_edge) begin
            state <= SERVE;
            lives <= START_LIVES;
          end
        end

        SERVE: begin
          if (start_edge) begin
            state     <= PLAY;
            playing   <= 1'b1;
            ball_hold <= 1'b0;
          end
        end

        PLAY: begin
          // A ball loss takes priority; a coincident level clear is discarded.
          if (ball_lost) begin
            playing   <= 1'b0;
            ball_hold <= 1'b1;
            if (lives > 2'd1) begin
              state      <= RESPAWN;
              lives      <= lives - 2'd1;
              frame_cnt  <= {2'b00, RESPAWN_FRAMES};
              show_lives <= ~RESPAWN_FRAMES[3];
            end else begin
              state     <= GAME_OVER;
              lives     <= 2'd0;
              frame_cnt <= GAMEOVER_FRAMES;
              game_over <= 1'b1;
            end
          end else if (bricks_cleared) begin
            state     <= SERVE;
            playing   <= 1'b0;
            ball_hold <= 1'b1;
            if (lives != 2'd3) begin
              lives <= lives + 2'd1;
            end
          end
        end

        RESPAWN: begin
          if (frame_start) begin
            if (frame_cnt <= 8'd1) begin
              state      <= SERVE;
              frame_cnt  <= 8'd0;
              show_lives <= 1'b1;
            end else begin
              frame_cnt  <= frame_cnt_dec;
              show_lives <= ~frame_cnt_dec[3];
            end
          end
        end

        GAME_OVER: begin
          if (frame_start) begin
            if (frame_cnt <= 8'd1) begin
              state     <= ATTRACT;
              frame_cnt <= 8'd0;
              game_over <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt_dec;
            end
          end
        end

        default: begin
          state      <= ATTRACT;
          lives      <= 2'd0;
          show_lives <= 1'b1;
          ball_hold  <= 1'b1;
          playing    <= 1'b0;
          game_over  <= 1'b0;
          frame_cnt  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/p18_lives_keeper.md
P18_LIVES_KEEPER -- requirements
Module: p18_lives_keeper

Interface
REQ-001 Parameter START_LIVES, default 2'd3, lives loaded at game start; legal values 1..3.
REQ-002 Parameter RESPAWN_FRAMES, default 6'd60, frames held in RESPAWN after a non-final ball loss; legal values 1..63.
REQ-003 Parameter GAMEOVER_FRAMES, default 8'd180, frames held in GAME_OVER; legal values 1..255.
REQ-004 Port clk, input, 1 bit, pixel clock; the only clock.
REQ-005 Port nRst, input, 1 bit, asynchronous active-low reset.
REQ-006 Port frame_start, input, 1 bit, one-cycle pulse once per video frame.
REQ-007 Port ball_lost, input, 1 bit, one-cycle pulse when the ball exits the bottom of the playfield.
REQ-008 Port bricks_cleared, input, 1 bit, one-cycle pulse when the level is cleared.
REQ-009 Port btn_start, input, 1 bit, raw asynchronous button level, active-high.
REQ-010 Port lives, output, 2 bits, remaining lives; drives the lives painter.
REQ-011 Port show_lives, output, 1 bit, lives-row display enable for blinking.
REQ-012 Port ball_hold, output, 1 bit, ball parked on the paddle.
REQ-013 Port playing, output, 1 bit, ball in flight.
REQ-014 Port game_over, output, 1 bit, game-over banner enable.

Function
REQ-015 btn_start SHALL pass through a 2-flop synchronizer; start_edge is the 0->1 transition of the synchronizer output, giving 3 cycles from input to edge.
REQ-016 The FSM SHALL have exactly the states ATTRACT, SERVE, PLAY, RESPAWN and GAME_OVER; all outputs SHALL be registered.
REQ-017 ATTRACT: lives=0, ball_hold=1, playing=0, game_over=0; on start_edge -> SERVE with lives<=START_LIVES.
REQ-018 SERVE: ball_hold=1; on start_edge -> PLAY.
REQ-019 PLAY: playing=1, ball_hold=0.
REQ-020 PLAY with ball_lost and lives>1 -> RESPAWN; lives<=lives-1; frame counter<=RESPAWN_FRAMES.
REQ-021 PLAY with ball_lost and lives==1 -> GAME_OVER; lives<=0; frame counter<=GAMEOVER_FRAMES.
REQ-022 PLAY with bricks_cleared SHALL do lives<=lives+1, saturating at 3, and -> SERVE.
REQ-023 Simultaneous ball_lost and bricks_cleared in PLAY: ball_lost wins and bricks_cleared is dropped.
REQ-024 ball_lost and bricks_cleared SHALL be ignored in every state other than PLAY.
REQ-025 The frame counter SHALL decrement on each frame_start in RESPAWN and GAME_OVER.
REQ-026 The state SHALL exit on the cycle after the frame_start that takes the counter from 1 to 0.
REQ-027 The required exit count is RESPAWN_FRAMES (or GAMEOVER_FRAMES) frame_start pulses.
REQ-028 RESPAWN: ball_hold=1; on expiry -> SERVE.
REQ-029 RESPAWN: show_lives = counter bit 3, inverted, giving an 8-frame blink.
REQ-030 show_lives SHALL be 1 in all states other than RESPAWN.
REQ-031 GAME_OVER: game_over=1, ball_hold=1; start_edge SHALL be ignored; on expiry -> ATTRACT.
REQ-032 A frame_start coincident with state entry SHALL NOT decrement the freshly loaded counter.
REQ-033 lives SHALL never underflow below 0 or exceed 3.

Reset
REQ-034 nRst low SHALL asynchronously force state ATTRACT and the following values: lives=0, ball_hold=1, playing=0, game_over=0, show_lives=1, counter=0.
REQ-035 nRst low SHALL asynchronously set both synchronizer flops and the edge register to 1, so a button held through reset produces no start_edge.
REQ-036 Reset asserted mid-operation (any state) SHALL return the block to ATTRACT with the REQ-034 values.

Verification
REQ-037 Scenario: reset, then btn_start pulse -> SERVE with lives=3 exactly 3-4 cycles later; second press -> playing=1.
REQ-038 Scenario: in PLAY with lives=3, ball_lost -> lives=2 and ball_hold=1, show_lives blinks, and SERVE is entered the cycle after the 60th frame_start.
REQ-039 Scenario: lives=1, ball_lost -> lives=0 and game_over=1; btn_start presses during GAME_OVER are ignored; ATTRACT is entered after the 180th frame_start.
REQ-040 Scenario: lives=3, bricks_cleared -> lives stays 3 and state is SERVE.
REQ-041 Scenario: lives=2, bricks_cleared -> lives=3 and state is SERVE.
REQ-042 Scenario: ball_lost and bricks_cleared in the same cycle with lives=2 -> lives=1 and state RESPAWN.
REQ-043 Scenario: btn_start held high through reset release -> state remains ATTRACT.
REQ-044 Scenario: nRst asserted during RESPAWN -> all outputs immediately take their REQ-034 values.
